// File: rtl/i2c_xfer_seq.sv
`timescale 1ns/1ps
// Byte-level I2C command sequencer in front of the M24C16 bit engine: decodes one
// command, steps the engine with a divided clock, and bounds each command with a timeout.
module i2c_xfer_seq #(
    parameter int DIV     = 2000,
    parameter int TIMEOUT = 400
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] cmd,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] wdata,
    input  logic [2:0] dev_sel,
    output logic [7:0] rdata,
    output logic       done,
    output logic [1:0] status,
    output logic       eng_clock,
    output logic       eng_nreset,
    output logic [7:0] eng_write_byte,
    output logic       eng_read,
    output logic       eng_do_start,
    output logic       eng_expect_ack,
    output logic       eng_do_stop,
    input  logic       eng_finished,
    input  logic [7:0] eng_read_byte
);

    typedef enum logic [2:0] {IDLE, RUN, DONE, ABORT, ILL} state_t;

    localparam logic [15:0] DIV_RELOAD  = 16'(DIV - 1);
    localparam logic [15:0] EDGE_LIMIT  = 16'(TIMEOUT);

    localparam logic [3:0] CMD_DEVSEL_READ     = 4'd0;
    localparam logic [3:0] CMD_DEVSEL_WRITE    = 4'd1;
    localparam logic [3:0] CMD_SETADDR         = 4'd2;
    localparam logic [3:0] CMD_DATA_READ       = 4'd3;
    localparam logic [3:0] CMD_DATA_READ_STOP  = 4'd4;
    localparam logic [3:0] CMD_DATA_WRITE      = 4'd5;
    localparam logic [3:0] CMD_DATA_WRITE_STOP = 4'd6;

    state_t      state;
    logic [15:0] div_cnt;
    logic [15:0] edge_cnt;

    assign cmd_ready = (state == IDLE);

    // Completion is only taken while eng_clock is high, and it is tested before the
    // timeout so a finish landing on the last allowed edge still counts as success.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            done           <= 1'b0;
            status         <= 2'd0;
            rdata          <= 8'h00;
            eng_clock      <= 1'b0;
            eng_nreset     <= 1'b0;
            eng_write_byte <= 8'h00;
            eng_read       <= 1'b0;
            eng_do_start   <= 1'b0;
            eng_expect_ack <= 1'b0;
            eng_do_stop    <= 1'b0;
            div_cnt        <= 16'd0;
            edge_cnt       <= 16'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (cmd <= CMD_DATA_WRITE_STOP) begin
                            case (cmd)
                                CMD_DEVSEL_READ, CMD_DEVSEL_WRITE: begin
                                    eng_write_byte <= {4'b1010, dev_sel, (cmd == CMD_DEVSEL_READ)};
                                    eng_do_start   <= 1'b1;
                                    eng_expect_ack <= 1'b1;
                                    eng_do_stop    <= 1'b0;
                                    eng_read       <= 1'b0;
                                end
                                CMD_DATA_READ, CMD_DATA_READ_STOP: begin
                                    eng_write_byte <= 8'h00;
                                    eng_do_start   <= 1'b0;
                                    eng_expect_ack <= (cmd == CMD_DATA_READ);
                                    eng_do_stop    <= (cmd == CMD_DATA_READ_STOP);
                                    eng_read       <= 1'b1;
                                end
                                default: begin
                                    eng_write_byte <= wdata;
                                    eng_do_start   <= 1'b0;
                                    eng_expect_ack <= 1'b1;
                                    eng_do_stop    <= (cmd == CMD_DATA_WRITE_STOP);
                                    eng_read       <= 1'b0;
                                end
                            endcase
                            eng_clock  <= 1'b0;
                            eng_nreset <= 1'b1;
                            div_cnt    <= DIV_RELOAD;
                            edge_cnt   <= 16'd0;
                            state      <= RUN;
                        end else begin
                            state <= ILL;
                        end
                    end
                end
                RUN: begin
                    if (div_cnt == 16'd0) begin
                        if (eng_finished && eng_clock) begin
                            state <= DONE;
                        end else if (edge_cnt == EDGE_LIMIT) begin
                            state <= ABORT;
                        end else begin
                            eng_clock <= ~eng_clock;
                            edge_cnt  <= edge_cnt + 16'd1;
                            div_cnt   <= DIV_RELOAD;
                        end
                    end else begin
                        div_cnt <= div_cnt - 16'd1;
                    end
                end
                DONE: begin
                    if (eng_read) begin
                        rdata <= eng_read_byte;
                    end
                    status <= 2'd0;
                    done   <= 1'b1;
                    state  <= IDLE;
                end
                // Holding the engine in reset keeps a stuck transfer from resuming.
                ABORT: begin
                    eng_nreset <= 1'b0;
                    eng_clock  <= 1'b0;
                    status     <= 2'd1;
                    done       <= 1'b1;
                    state      <= IDLE;
                end
                ILL: begin
                    status <= 2'd2;
                    done   <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_xfer_seq.sv
`timescale 1ns/1ps
// Directed bench for i2c_xfer_seq with a behavioural engine that raises finished after
// a chosen number of eng_clock rises counted from command acceptance.
module tb_i2c_xfer_seq;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] cmd = 4'd0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [7:0] wdata = 8'h00;
    logic [2:0] dev_sel = 3'b000;
    logic [7:0] rdata;
    logic       done;
    logic [1:0] status;
    logic       eng_clock;
    logic       eng_nreset;
    logic [7:0] eng_write_byte;
    logic       eng_read;
    logic       eng_do_start;
    logic       eng_expect_ack;
    logic       eng_do_stop;
    logic       eng_finished;
    logic [7:0] eng_read_byte = 8'h00;

    int checks = 0;
    int failures = 0;
    int finish_after = 0;
    int rises = 0;
    logic eng_clock_q = 1'b0;

    i2c_xfer_seq #(.DIV(4), .TIMEOUT(10)) dut (
        .clock(clock),
        .reset(reset),
        .cmd(cmd),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .wdata(wdata),
        .dev_sel(dev_sel),
        .rdata(rdata),
        .done(done),
        .status(status),
        .eng_clock(eng_clock),
        .eng_nreset(eng_nreset),
        .eng_write_byte(eng_write_byte),
        .eng_read(eng_read),
        .eng_do_start(eng_do_start),
        .eng_expect_ack(eng_expect_ack),
        .eng_do_stop(eng_do_stop),
        .eng_finished(eng_finished),
        .eng_read_byte(eng_read_byte)
    );

    always #5 clock = ~clock;

    // Behavioural engine: rises are counted per command, restarting at acceptance.
    always @(posedge clock) begin
        eng_clock_q <= eng_clock;
        if (cmd_valid && cmd_ready)
            rises <= 0;
        else if (eng_clock && !eng_clock_q)
            rises <= rises + 1;
    end

    assign eng_finished = (finish_after != 0) && (rises >= finish_after);

    task automatic check_output(input string tag, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    // Waits for done with a bound; returns cycles since the acceptance edge, or -1.
    task automatic wait_done(output int cycles);
        cycles = -1;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clock);
            #1;
            if (done) begin
                cycles = n;
                break;
            end
        end
    endtask

    task automatic apply_stimulus(input logic [3:0] c, input logic [7:0] wd,
                                  input logic [2:0] ds, output int cycles);
        @(negedge clock);
        cmd       = c;
        wdata     = wd;
        dev_sel   = ds;
        cmd_valid = 1'b1;
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
        wait_done(cycles);
    endtask

    int cyc;
    int done_seen;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        repeat (3) @(posedge clock);
        #1;
        check_output("rst_cmd_ready", 16'(cmd_ready), 16'd1);
        check_output("rst_done", 16'(done), 16'd0);
        check_output("rst_status", 16'(status), 16'd0);
        check_output("rst_rdata", 16'(rdata), 16'h00);
        check_output("rst_eng_clock", 16'(eng_clock), 16'd0);
        check_output("rst_eng_nreset", 16'(eng_nreset), 16'd0);
        check_output("rst_eng_ctrl", 16'({eng_write_byte, eng_read, eng_do_start, eng_expect_ack, eng_do_stop}), 16'h0);
        @(negedge clock);
        reset = 1'b0;

        // DEVSEL_WRITE, dev_sel=101: finished after 3 rises -> first high evaluation at 24.
        finish_after = 3;
        apply_stimulus(4'd1, 8'h00, 3'b101, cyc);
        check_output("devsel_done_cycle", 16'(cyc), 16'd25);
        check_output("devsel_status", 16'(status), 16'd0);
        check_output("devsel_write_byte", 16'(eng_write_byte), 16'h00AA);
        check_output("devsel_start", 16'(eng_do_start), 16'd1);
        check_output("devsel_ack", 16'(eng_expect_ack), 16'd1);
        check_output("devsel_stop_read", 16'({eng_do_stop, eng_read}), 16'd0);
        check_output("devsel_nreset", 16'(eng_nreset), 16'd1);
        @(posedge clock);
        #1;
        check_output("devsel_done_once", 16'(done), 16'd0);

        // DATA_READ_STOP returning 5C, finishing on the last edge before the timeout.
        finish_after  = 5;
        eng_read_byte = 8'h5C;
        apply_stimulus(4'd4, 8'hFF, 3'b000, cyc);
        check_output("rdstop_done_cycle", 16'(cyc), 16'd41);
        check_output("rdstop_status", 16'(status), 16'd0);
        check_output("rdstop_rdata", 16'(rdata), 16'h005C);
        check_output("rdstop_ctrl", 16'({eng_read, eng_do_start, eng_expect_ack, eng_do_stop}), 16'b1001);
        check_output("rdstop_write_byte", 16'(eng_write_byte), 16'h0000);

        // DATA_READ that never finishes: abort at (10+1)*4+1, rdata untouched.
        finish_after  = 0;
        eng_read_byte = 8'h11;
        apply_stimulus(4'd3, 8'h00, 3'b000, cyc);
        check_output("tmo_done_cycle", 16'(cyc), 16'd45);
        check_output("tmo_status", 16'(status), 16'd1);
        check_output("tmo_nreset", 16'(eng_nreset), 16'd0);
        check_output("tmo_eng_clock", 16'(eng_clock), 16'd0);
        check_output("tmo_rdata", 16'(rdata), 16'h005C);
        repeat (3) @(posedge clock);
        #1;
        check_output("tmo_nreset_held", 16'(eng_nreset), 16'd0);

        // Illegal cmd=9 with cmd_valid held, then DATA_WRITE 3E accepted right after done.
        finish_after = 1;
        @(negedge clock);
        cmd       = 4'd9;
        wdata     = 8'h00;
        cmd_valid = 1'b1;
        @(posedge clock);
        #1;
        cmd   = 4'd5;
        wdata = 8'h3E;
        @(posedge clock);
        #1;
        check_output("ill_done", 16'(done), 16'd1);
        check_output("ill_status", 16'(status), 16'd2);
        check_output("ill_eng_clock", 16'(eng_clock), 16'd0);
        check_output("ill_nreset", 16'(eng_nreset), 16'd0);
        check_output("ill_write_byte", 16'(eng_write_byte), 16'h0000);
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
        check_output("b2b_accepted", 16'(cmd_ready), 16'd0);
        check_output("b2b_write_byte", 16'(eng_write_byte), 16'h003E);
        check_output("b2b_nreset", 16'(eng_nreset), 16'd1);
        wait_done(cyc);
        check_output("b2b_done_cycle", 16'(cyc), 16'd9);
        check_output("b2b_status", 16'(status), 16'd0);

        // Reset in the middle of a SETADDR: everything drops at once and no done follows.
        finish_after = 0;
        @(negedge clock);
        cmd       = 4'd2;
        wdata     = 8'h77;
        cmd_valid = 1'b1;
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
        repeat (6) @(posedge clock);
        #1;
        check_output("mid_eng_clock_high", 16'(eng_clock), 16'd1);
        #2;
        reset = 1'b1;
        #1;
        check_output("mid_cmd_ready", 16'(cmd_ready), 16'd1);
        check_output("mid_done", 16'(done), 16'd0);
        check_output("mid_rdata", 16'(rdata), 16'h0000);
        check_output("mid_eng_clock", 16'(eng_clock), 16'd0);
        check_output("mid_eng_nreset", 16'(eng_nreset), 16'd0);
        check_output("mid_eng_ctrl", 16'({eng_write_byte, eng_read, eng_do_start, eng_expect_ack, eng_do_stop}), 16'h0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clock);
            #1;
            if (done) done_seen++;
        end
        check_output("mid_no_done", 16'(done_seen), 16'd0);
        check_output("mid_still_idle", 16'(cmd_ready), 16'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
